// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pixel pipeline: frame geometry defaults, the
// transmitter state encoding and the stream beat carried between stages.
package sobel_pkg;

    localparam int DEF_WIDTH  = 512;
    localparam int DEF_HEIGHT = 512;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO of stream beats; the head entry is presented combinationally.
// The beat type is a parameter so the pixel width can follow the top level.
module stream_skid_fifo
    import sobel_pkg::*;
#(
    parameter type beat_T = beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  beat_T      push_beat_i,
    input  logic       pop_i,
    output beat_T      head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    beat_T      mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only accepted when the head leaves this cycle
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + 2'd1;
        if (do_pop && !do_push) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_beat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/pixel_stream_source.sv
// Raster frame transmitter: reads a WIDTH x HEIGHT frame from synchronous memory
// and streams it with sof/eol/eof. Optional PIXEL_STREAM_TEST_PATTERN_EN adds x^y pattern mode.
module pixel_stream_source
    import sobel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [DATA_W-1:0] px_data,
    output logic              px_sof,
    output logic              px_eol,
    output logic              px_eof
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [XW-1:0]     LAST_X    = XW'(WIDTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } px_beat_t;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q;
    logic              sof_q, eol_q, eof_q;
    logic              issue, pop, slot_free, last_issue;
    px_beat_t          push_beat, head;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_cnt;

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    logic              pat_q;
    logic [DATA_W-1:0] pat_data_q;
`endif

    assign pop        = !fifo_empty && px_ready;
    assign last_issue = (addr_q == LAST_ADDR);
    // Buffered + in-flight beats stay at most 2; a transfer this cycle frees a slot
    assign slot_free  = (fifo_cnt == 2'd0) || (!fifo_full && !inflight_q);
    assign issue      = (state_q == RUN) && (slot_free || pop);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (last_issue) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (x_q == LAST_X) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            DRAIN:   if (pop && head.eof) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            inflight_q <= issue;
            // Markers travel alongside the read so they meet its data at the FIFO
            if (issue) begin
                sof_q <= (x_q == '0) && (y_q == '0);
                eol_q <= (x_q == LAST_X);
                eof_q <= last_issue;
            end
        end
    end

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q      <= 1'b0;
            pat_data_q <= '0;
        end else begin
            if (state_q == IDLE && start) pat_q <= pattern_sel;
            if (issue) pat_data_q <= DATA_W'(32'(x_q) ^ 32'(y_q));
        end
    end

    assign mem_rd_en = issue && !pat_q;
`else
    assign mem_rd_en = issue;
`endif

    always_comb begin
        push_beat.data = mem_rd_data;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        if (pat_q) push_beat.data = pat_data_q;
`endif
        push_beat.sof = sof_q;
        push_beat.eol = eol_q;
        push_beat.eof = eof_q;
    end

    stream_skid_fifo #(.beat_T(px_beat_t)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_beat_i(push_beat),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign mem_addr = addr_q;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign px_valid = !fifo_empty;
    assign px_data  = px_valid ? head.data : '0;
    assign px_sof   = px_valid && head.sof;
    assign px_eol   = px_valid && head.eol;
    assign px_eof   = px_valid && head.eof;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source on a 4x3 frame: stall-pattern table, random ready,
// ignored starts, mid-frame reset and (when enabled) the x^y test pattern.
module tb_pixel_stream_source;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pattern_sel = 1'b0;
    logic       busy, done, mem_rd_en, px_valid, px_sof, px_eol, px_eof;
    logic       px_ready = 1'b1;
    logic [7:0] mem_addr, px_data;
    logic [7:0] mem_rd_data = 8'h00;

    always #5 clk = ~clk;

    pixel_stream_source #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .px_sof     (px_sof),
        .px_eol     (px_eol),
        .px_eof     (px_eof)
    );

    // Frame memory holds mem[a] = a, one-cycle read latency
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_beat_t;

    typedef struct {
        int lo;
        int hi;
        bit extra;
        int exp_done;
    } vec_t;

    exp_beat_t sb[$];
    int  errors = 0, checks = 0;
    int  beats = 0, issued = 0, max_out = 0;
    int  gate_viol = 0, hold_viol = 0;
    int  nsof = 0, neol = 0, neof = 0;
    bit  hold_pend = 1'b0;
    logic [10:0] held;
    wire  [10:0] cur    = {px_data, px_sof, px_eol, px_eof};
    wire  [22:0] outvec = {busy, done, mem_rd_en, mem_addr, px_valid, px_data, px_sof, px_eol, px_eof};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input bit pat);
        exp_beat_t e;
        for (int i = 0; i < N; i++) begin
            e.data = pat ? 8'((i % W) ^ (i / W)) : 8'(i);
            e.sof  = (i == 0);
            e.eol  = ((i % W) == W - 1);
            e.eof  = (i == N - 1);
            sb.push_back(e);
        end
    endtask

    // Called once per cycle at the falling edge
    task automatic sample();
        exp_beat_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
            return;
        end
        if (!px_valid && (cur != '0)) gate_viol++;
        if (hold_pend && (!px_valid || cur != held)) hold_viol++;
        if (mem_rd_en) issued++;
        if (px_valid && px_ready) begin
            beats++;
            nsof += int'(px_sof);
            neol += int'(px_eol);
            neof += int'(px_eof);
            if (sb.size() == 0) begin
                chk("unexpected beat", cur, 0);
            end else begin
                e = sb.pop_front();
                chk("beat", cur, e);
            end
        end
        if (issued - beats > max_out) max_out = issued - beats;
        hold_pend = px_valid && !px_ready;
        held      = cur;
    endtask

    // Starts a frame; cycle k=0 is the cycle right after the accepting edge
    task automatic run_frame(input int lo, input int hi, input bit extra, input int exp_d,
                             input bit rnd, input bit pat, output int fv, output int dc);
        int b0;
        fv = -1;
        dc = -1;
        b0 = beats;
        pattern_sel = pat;
        push_frame(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            px_ready = rnd ? 1'($urandom_range(0, 1)) : !(k >= lo && k <= hi);
            start    = extra && (k == 4 || k == exp_d - 1 || k == exp_d);
            @(negedge clk); sample();
            if (k == 0) chk("busy after accept", busy, 1);
            if (px_valid && fv < 0) fv = k;
            if (done) begin
                dc = k;
                chk("busy low at done", busy, 0);
                @(posedge clk); #1;
                start = 1'b0;
                px_ready = 1'b1;
                @(negedge clk); sample();
                chk("done one cycle", done, 0);
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        px_ready = 1'b1;
        chk("beats per frame", beats - b0, N);
        chk("scoreboard drained", sb.size(), 0);
        sb.delete();
    endtask

    vec_t tbl[5];
    int   fv, dc, b0, i0, busy_seen, done_seen;

    initial begin
        // Stall windows are cycles after acceptance; each stalled cycle while data
        // is waiting pushes completion out by one
        tbl[0] = '{lo: -1, hi: -1, extra: 1'b0, exp_done: 14};
        tbl[1] = '{lo:  3, hi:  7, extra: 1'b0, exp_done: 19};
        tbl[2] = '{lo:  2, hi:  2, extra: 1'b0, exp_done: 15};
        tbl[3] = '{lo:  2, hi:  3, extra: 1'b1, exp_done: 16};
        tbl[4] = '{lo: 10, hi: 12, extra: 1'b1, exp_done: 17};

        #1;
        chk("outputs in reset", outvec, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); sample();
            chk("idle outputs", outvec, 0);
            @(posedge clk); #1;
        end

        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].lo, tbl[v].hi, tbl[v].extra, tbl[v].exp_done, 1'b0, 1'b0, fv, dc);
            chk("first valid latency", fv, 2);
            chk("done latency", dc, tbl[v].exp_done);
            b0 = beats;
            busy_seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); sample();
                busy_seen += int'(busy);
                @(posedge clk); #1;
            end
            chk("no second frame busy", busy_seen, 0);
            chk("no second frame beats", beats - b0, 0);
        end
        chk("stable while stalled", hold_viol, 0);
        chk("max outstanding ok", max_out <= 2, 1);

        nsof = 0; neol = 0; neof = 0; b0 = beats;
        for (int f = 0; f < 30; f++) begin
            run_frame(-1, -1, 1'b0, 0, 1'b1, 1'b0, fv, dc);
            chk("random first valid", fv, 2);
            chk("random frame done", dc >= 0, 1);
        end
        chk("random beats", beats - b0, 30 * N);
        chk("random sof count", nsof, 30);
        chk("random eol count", neol, 30 * H);
        chk("random eof count", neof, 30);

        // Abandon a frame after five transfers
        push_frame(1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b0 = beats;
        for (int k = 0; k < 50 && beats - b0 < 5; k++) begin
            @(negedge clk); sample();
            @(posedge clk); #1;
        end
        chk("reached pixel 5", beats - b0, 5);
        rst_n = 1'b0;
        #1;
        chk("outputs at mid-frame reset", outvec, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issued = 0; beats = 0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); sample();
            done_seen += int'(done) + int'(busy) + int'(px_valid);
            @(posedge clk); #1;
        end
        chk("no activity after abort", done_seen, 0);
        run_frame(-1, -1, 1'b0, 14, 1'b0, 1'b0, fv, dc);
        chk("restart first valid", fv, 2);
        chk("restart done latency", dc, 14);

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        i0 = issued;
        run_frame(-1, -1, 1'b0, 14, 1'b0, 1'b1, fv, dc);
        chk("pattern done latency", dc, 14);
        chk("pattern issues no reads", issued - i0, 0);
`else
        i0 = 0;
`endif

        chk("markers gated by valid", gate_viol, 0);
        chk("stable while stalled end", hold_viol, 0);
        chk("max outstanding end", max_out <= 2, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
